mc6809_dma_arb: RTL

MC6809_DMA_ARB -- requirements
Module: mc6809_dma_arb

---
 rtl/mc6809_dma_arb_if.sv | 12 +
 rtl/mc6809_dma_arb.sv | 73 +++++++
 2 files changed

// File: rtl/mc6809_dma_arb_if.sv
// mc6809_dma_arb_if: CPU bus status, DMA requests and arbiter outputs for the 6809 DMA arbiter
interface mc6809_dma_arb_if;
  logic       BA;
  logic       BS;
  logic [1:0] req;
  logic       nDMABREQ;
  logic [1:0] gnt;
  logic       busy;
  logic [3:0] burst_cnt;
  modport slave (input BA, BS, req, output nDMABREQ, gnt, busy, burst_cnt);
  modport master (output BA, BS, req, input nDMABREQ, gnt, busy, burst_cnt);
endinterface

// File: rtl/mc6809_dma_arb.sv
// mc6809_dma_arb: two-requester DMA arbiter for the MC6809 DMA/BREQ bus handoff.
// Define MC6809_DMA_RR_EN for round-robin tie breaking; otherwise requester 0 has fixed priority.
module mc6809_dma_arb #(
  parameter int BURST_MAX = 14
) (
  input logic CLK,
  input logic nRESET,
  mc6809_dma_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;
  localparam logic [3:0] MAX = 4'(BURST_MAX);
  state_t     state_q;
  logic [1:0] gnt_q;
  logic       ndma_q;
  logic       busy_q;
  logic [3:0] cnt_q;
  logic       win_d;
  logic       any_req;
  logic       done_d;
  assign any_req = bus.req != 2'b00;
  // the CPU reclaiming the bus (BA low) ends the burst as surely as the owner dropping its request
  assign done_d = (|(gnt_q & ~bus.req)) || cnt_q == MAX || !bus.BA;
`ifdef MC6809_DMA_RR_EN
  logic last_q;
  assign win_d = (&bus.req) ? ~last_q : ~bus.req[0];
  always_ff @(posedge CLK) begin
    if (!nRESET) last_q <= 1'b1;
    else if (state_q == REQ && bus.BA && bus.BS && any_req) last_q <= win_d;
  end
`else
  assign win_d = ~bus.req[0];
`endif
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      ndma_q  <= 1'b1;
      busy_q  <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          state_q <= REQ;
          ndma_q  <= 1'b0;
          busy_q  <= 1'b1;
        end
        REQ: if (bus.BA && bus.BS && any_req) begin
          state_q <= GRANT;
          gnt_q   <= win_d ? 2'b10 : 2'b01;
          cnt_q   <= 4'd1;
        end else if (!any_req) begin
          state_q <= RELEASE;
          ndma_q  <= 1'b1;
        end
        GRANT: if (done_d) begin
          state_q <= RELEASE;
          gnt_q   <= 2'b00;
          cnt_q   <= 4'd0;
          ndma_q  <= 1'b1;
        end else cnt_q <= cnt_q + 4'd1;
        RELEASE: if (!bus.BA) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.nDMABREQ  = ndma_q;
  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.burst_cnt = cnt_q;
endmodule
